ysyx_22050019_scoreboard: RTL and testbench

//  Producer-side companion to the ID-stage forwarding network. Tracks every
//  in-flight GPR write from issue (ID->EXU fire) to writeback. Tells ID which

---
 rtl/ysyx_22050019_scoreboard_if.sv | 34 +++
 rtl/ysyx_22050019_scoreboard.sv | 86 ++++++++
 tb/tb_ysyx_22050019_scoreboard.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_scoreboard_if.sv
// rtl/ysyx_22050019_scoreboard_if.sv - ID-stage issue/writeback/query bundle for the GPR scoreboard
interface ysyx_22050019_scoreboard_if;
    logic       flush_i;
    logic       issue_fire_i;
    logic       issue_wen_i;
    logic [4:0] issue_rd_i;
    logic       issue_is_load_i;
    logic       ld_done_i;
    logic [4:0] ld_done_rd_i;
    logic       wb_valid_i;
    logic [4:0] wb_rd_i;
    logic [4:0] rs1_i;
    logic [4:0] rs2_i;
    logic       rs1_used_i;
    logic       rs2_used_i;
    logic       rs1_busy_o;
    logic       rs2_busy_o;
    logic       stall_o;
    logic       underflow_err_o;

    modport master (
        output flush_i, issue_fire_i, issue_wen_i, issue_rd_i, issue_is_load_i,
        output ld_done_i, ld_done_rd_i, wb_valid_i, wb_rd_i,
        output rs1_i, rs2_i, rs1_used_i, rs2_used_i,
        input  rs1_busy_o, rs2_busy_o, stall_o, underflow_err_o
    );

    modport slave (
        input  flush_i, issue_fire_i, issue_wen_i, issue_rd_i, issue_is_load_i,
        input  ld_done_i, ld_done_rd_i, wb_valid_i, wb_rd_i,
        input  rs1_i, rs2_i, rs1_used_i, rs2_used_i,
        output rs1_busy_o, rs2_busy_o, stall_o, underflow_err_o
    );
endinterface

// File: rtl/ysyx_22050019_scoreboard.sv
// rtl/ysyx_22050019_scoreboard.sv - in-flight GPR writer tracking with load-use and saturation stall
module ysyx_22050019_scoreboard #(
    parameter int NR_REG = 32,
    parameter int CNT_W  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_22050019_scoreboard_if.slave     sb
);
    localparam int RW = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt     [NR_REG];
    logic [CNT_W-1:0] cnt_nxt [NR_REG];
    logic [NR_REG-1:0] ldp, ldp_nxt;
    logic              err_q, err_set;

    logic iss_ev, wb_ev, ld_ev;
    assign iss_ev = sb.issue_fire_i & sb.issue_wen_i & (sb.issue_rd_i != '0);
    assign wb_ev  = sb.wb_valid_i & (sb.wb_rd_i != '0);
    assign ld_ev  = sb.ld_done_i & (sb.ld_done_rd_i != '0);

    // Entry 0 is never written here, so it stays at its reset value of zero.
    always_comb begin
        cnt_nxt = cnt;
        ldp_nxt = ldp;
        err_set = 1'b0;
        for (int r = 1; r < NR_REG; r++) begin
            if (sb.flush_i) begin
                cnt_nxt[r] = '0;
                ldp_nxt[r] = 1'b0;
            end else begin
                if (ld_ev && sb.ld_done_rd_i == RW'(r)) begin
                    ldp_nxt[r] = 1'b0;
                end
                // A same-register issue and writeback cancel out on the count.
                if (wb_ev && sb.wb_rd_i == RW'(r) &&
                    !(iss_ev && sb.issue_rd_i == RW'(r))) begin
                    if (cnt[r] != '0) begin
                        cnt_nxt[r] = cnt[r] - 1'b1;
                        if (cnt[r] == CNT_ONE) begin
                            ldp_nxt[r] = 1'b0;
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end
                if (iss_ev && sb.issue_rd_i == RW'(r)) begin
                    if (!(wb_ev && sb.wb_rd_i == RW'(r)) && cnt[r] != CNT_MAX) begin
                        cnt_nxt[r] = cnt[r] + 1'b1;
                    end
                    ldp_nxt[r] = sb.issue_is_load_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR_REG; r++) begin
                cnt[r] <= '0;
            end
            ldp   <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NR_REG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            ldp <= ldp_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Queries look only at registered state; same-cycle paths belong to forwarding.
    logic load_haz, sat_haz;
    assign sb.rs1_busy_o = (sb.rs1_i != '0) & (cnt[sb.rs1_i] != '0);
    assign sb.rs2_busy_o = (sb.rs2_i != '0) & (cnt[sb.rs2_i] != '0);
    assign load_haz = (sb.rs1_used_i & (sb.rs1_i != '0) & ldp[sb.rs1_i]) |
                      (sb.rs2_used_i & (sb.rs2_i != '0) & ldp[sb.rs2_i]);
    assign sat_haz  = (cnt[sb.issue_rd_i] == CNT_MAX) & sb.issue_wen_i & (sb.issue_rd_i != '0);
    assign sb.stall_o         = load_haz | sat_haz;
    assign sb.underflow_err_o = err_q;
endmodule

// File: tb/tb_ysyx_22050019_scoreboard.sv
// tb/tb_ysyx_22050019_scoreboard.sv - vector table, corner sequences and random model check of the scoreboard
module tb_ysyx_22050019_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22050019_scoreboard_if sb_if ();
    ysyx_22050019_scoreboard #(.NR_REG(32), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    localparam int MAXC = 3;
    int checks = 0;
    int errors = 0;
    int m_cnt [32];
    bit m_ldp [32];
    bit m_err;

    typedef struct {
        bit fl, fi, we, il;
        logic [4:0] rd;
        bit ld;
        logic [4:0] ld_rd;
        bit wb;
        logic [4:0] wb_rd;
        logic [4:0] r1;
        bit u1;
        logic [4:0] r2;
        bit u2;
        bit b1, b2, st, er;
    } vec_t;
    vec_t vt [17];

    function automatic vec_t mkv(bit fl, bit fi, bit we, bit il, logic [4:0] rd,
                                 bit ld, logic [4:0] ldrd, bit wb, logic [4:0] wbrd,
                                 logic [4:0] r1, bit u1, logic [4:0] r2, bit u2,
                                 bit b1, bit b2, bit st, bit er);
        vec_t v;
        v.fl = fl; v.fi = fi; v.we = we; v.il = il; v.rd = rd;
        v.ld = ld; v.ld_rd = ldrd; v.wb = wb; v.wb_rd = wbrd;
        v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2;
        v.b1 = b1; v.b2 = b2; v.st = st; v.er = er;
        return v;
    endfunction

    task automatic check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0;
            m_ldp[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Events are applied in program order: load completes, oldest writer retires, new writer issues.
    task automatic model_edge();
        bit iss, w, l;
        iss = sb_if.issue_fire_i && sb_if.issue_wen_i && sb_if.issue_rd_i != 0;
        w   = sb_if.wb_valid_i && sb_if.wb_rd_i != 0;
        l   = sb_if.ld_done_i && sb_if.ld_done_rd_i != 0;
        if (sb_if.flush_i) begin
            for (int i = 0; i < 32; i++) begin
                m_cnt[i] = 0;
                m_ldp[i] = 1'b0;
            end
        end else begin
            if (l) m_ldp[sb_if.ld_done_rd_i] = 1'b0;
            if (w) begin
                if (m_cnt[sb_if.wb_rd_i] > 0) begin
                    m_cnt[sb_if.wb_rd_i]--;
                    if (m_cnt[sb_if.wb_rd_i] == 0) m_ldp[sb_if.wb_rd_i] = 1'b0;
                end else if (!(iss && sb_if.issue_rd_i == sb_if.wb_rd_i)) begin
                    m_err = 1'b1;
                end
            end
            if (iss) begin
                if (m_cnt[sb_if.issue_rd_i] < MAXC) m_cnt[sb_if.issue_rd_i]++;
                m_ldp[sb_if.issue_rd_i] = sb_if.issue_is_load_i;
            end
        end
    endtask

    function automatic bit m_stall();
        bit lh, sh;
        lh = (sb_if.rs1_used_i && sb_if.rs1_i != 0 && m_ldp[sb_if.rs1_i]) ||
             (sb_if.rs2_used_i && sb_if.rs2_i != 0 && m_ldp[sb_if.rs2_i]);
        sh = sb_if.issue_wen_i && sb_if.issue_rd_i != 0 && m_cnt[sb_if.issue_rd_i] == MAXC;
        return lh || sh;
    endfunction

    task automatic set_in(bit fl, bit fi, bit we, bit il, logic [4:0] rd, bit ld, logic [4:0] ldrd,
                          bit wb, logic [4:0] wbrd, logic [4:0] r1, bit u1, logic [4:0] r2, bit u2);
        sb_if.flush_i = fl; sb_if.issue_fire_i = fi; sb_if.issue_wen_i = we;
        sb_if.issue_is_load_i = il; sb_if.issue_rd_i = rd;
        sb_if.ld_done_i = ld; sb_if.ld_done_rd_i = ldrd;
        sb_if.wb_valid_i = wb; sb_if.wb_rd_i = wbrd;
        sb_if.rs1_i = r1; sb_if.rs1_used_i = u1; sb_if.rs2_i = r2; sb_if.rs2_used_i = u2;
    endtask

    // One clock: model sees the pre-edge inputs, pulses drop 1 time unit after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        sb_if.flush_i = 1'b0; sb_if.issue_fire_i = 1'b0;
        sb_if.ld_done_i = 1'b0; sb_if.wb_valid_i = 1'b0;
    endtask

    task automatic check_model(string tag);
        check({tag, "_rs1_busy"}, sb_if.rs1_busy_o, sb_if.rs1_i != 0 && m_cnt[sb_if.rs1_i] != 0);
        check({tag, "_rs2_busy"}, sb_if.rs2_busy_o, sb_if.rs2_i != 0 && m_cnt[sb_if.rs2_i] != 0);
        check({tag, "_stall"}, sb_if.stall_o, m_stall());
        check({tag, "_err"}, sb_if.underflow_err_o, m_err);
    endtask

    initial begin
        vt[0]  = mkv(0,1,1,1,7,  0,0, 0,0,  7,1,0,0, 1,0,1,0);
        vt[1]  = mkv(0,0,1,0,7,  1,7, 0,0,  7,1,0,0, 1,0,0,0);
        vt[2]  = mkv(0,0,1,0,7,  0,0, 1,7,  7,1,0,0, 0,0,0,0);
        vt[3]  = mkv(0,1,1,0,3,  0,0, 0,0,  3,1,0,0, 1,0,0,0);
        vt[4]  = mkv(0,1,1,0,3,  0,0, 0,0,  3,1,0,0, 1,0,0,0);
        vt[5]  = mkv(0,1,1,0,3,  0,0, 0,0,  3,1,0,0, 1,0,1,0);
        vt[6]  = mkv(0,0,1,0,3,  0,0, 1,3,  3,1,0,0, 1,0,0,0);
        vt[7]  = mkv(0,0,0,0,3,  0,0, 1,3,  3,1,0,0, 1,0,0,0);
        vt[8]  = mkv(0,0,0,0,3,  0,0, 1,3,  3,1,0,0, 0,0,0,0);
        vt[9]  = mkv(0,1,1,0,9,  0,0, 0,0,  0,0,9,1, 0,1,0,0);
        vt[10] = mkv(0,1,1,1,9,  0,0, 1,9,  0,0,9,1, 0,1,1,0);
        vt[11] = mkv(0,0,0,0,0,  0,0, 1,9,  0,0,9,1, 0,0,0,0);
        vt[12] = mkv(0,0,0,0,0,  0,0, 1,12, 12,1,0,0, 0,0,0,1);
        vt[13] = mkv(0,1,1,0,0,  0,0, 1,0,  0,1,0,0, 0,0,0,1);
        vt[14] = mkv(0,1,1,1,4,  0,0, 0,0,  4,1,0,0, 1,0,1,1);
        vt[15] = mkv(0,1,1,1,6,  0,0, 0,0,  6,1,0,0, 1,0,1,1);
        vt[16] = mkv(1,1,1,1,4,  0,0, 0,0,  4,1,6,1, 0,0,0,1);

        set_in(0,0,0,0,0, 0,0, 0,0, 5,1,5,1);
        rst_n = 1'b0;
        model_reset();
        #12;
        check("reset_rs1_busy", sb_if.rs1_busy_o, 1'b0);
        check("reset_stall", sb_if.stall_o, 1'b0);
        check("reset_err", sb_if.underflow_err_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            set_in(vt[i].fl, vt[i].fi, vt[i].we, vt[i].il, vt[i].rd, vt[i].ld, vt[i].ld_rd,
                   vt[i].wb, vt[i].wb_rd, vt[i].r1, vt[i].u1, vt[i].r2, vt[i].u2);
            step();
            check($sformatf("vec%0d_rs1_busy", i), sb_if.rs1_busy_o, vt[i].b1);
            check($sformatf("vec%0d_rs2_busy", i), sb_if.rs2_busy_o, vt[i].b2);
            check($sformatf("vec%0d_stall", i), sb_if.stall_o, vt[i].st);
            check($sformatf("vec%0d_err", i), sb_if.underflow_err_o, vt[i].er);
        end

        // Asynchronous reset mid-run with two load writers pending on x5 and a set error flag.
        set_in(0,0,0,0,0, 0,0, 1,12, 0,0,0,0);
        step();
        set_in(0,1,1,1,5, 0,0, 0,0, 5,1,0,0);
        step();
        set_in(0,1,1,1,5, 0,0, 0,0, 5,1,0,0);
        sb_if.rs1_used_i = 1'b0;
        step();
        sb_if.rs1_used_i = 1'b1;
        #1;
        check("mid_busy_before_rst", sb_if.rs1_busy_o, 1'b1);
        check("mid_stall_before_rst", sb_if.stall_o, 1'b1);
        check("mid_err_before_rst", sb_if.underflow_err_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", sb_if.rs1_busy_o, 1'b0);
        check("async_rst_stall", sb_if.stall_o, 1'b0);
        check("async_rst_err", sb_if.underflow_err_o, 1'b0);
        model_reset();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 500; n++) begin
            logic [4:0] rd, wbrd, ldrd, r1, r2;
            bit fl, fi, we, il, ld, wb, u1, u2;
            rd = 5'($urandom_range(0, 7)); wbrd = 5'($urandom_range(0, 7));
            ldrd = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
            fl = ($urandom_range(0, 29) == 0);
            we = ($urandom_range(0, 3) != 0); il = $urandom_range(0, 1);
            fi = $urandom_range(0, 1);
            ld = ($urandom_range(0, 2) == 0);
            wb = ($urandom_range(0, 2) == 0) && !fl;
            u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1);
            set_in(fl, 1'b0, we, il, rd, ld, ldrd, 1'b0, wbrd, r1, u1, r2, u2);
            if (m_stall()) fi = 1'b0;
            if (wb && fi && we && rd == wbrd && m_cnt[wbrd] == 0) wb = 1'b0;
            sb_if.issue_fire_i = fi;
            sb_if.wb_valid_i = wb;
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
